// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared constants and types for the BNN weight-load path:
//               layer codes, per-layer slot counts, record length and the
//               offset field type.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  // Layer codes carried in the low two bits of record byte 0
  localparam logic [1:0] LAYER_CONV1 = 2'd1;
  localparam logic [1:0] LAYER_CONV2 = 2'd2;
  localparam logic [1:0] LAYER_FC    = 2'd3;

  // Number of addressable slots per layer
  localparam int N_K1 = 90;
  localparam int N_K2 = 1080;
  localparam int N_FC = 10;

  // Bytes per weight record on the input stream
  localparam int REC_BYTES = 8;

  typedef logic [7:0] d_offset_t;

endpackage
`default_nettype wire

// File: rtl/bnn_rec_check.sv
`default_nettype none
// ============================================================================
// Module      : bnn_rec_check
// Description : Combinational record validator. A record is valid when its
//               layer code is non-zero and its address lies below the slot
//               count of that layer.
// Ports       : layer [1:0]      - layer code (1=conv1, 2=conv2, 3=fc)
//               addr  [ADDR_W-1] - slot index
//               valid            - high when (layer, addr) names a real slot
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_rec_check #(
  parameter int ADDR_W = 11,
  parameter int N_K1   = bnn_pkg::N_K1,
  parameter int N_K2   = bnn_pkg::N_K2,
  parameter int N_FC   = bnn_pkg::N_FC
) (
  input  logic [1:0]        layer,
  input  logic [ADDR_W-1:0] addr,
  output logic              valid
);
  import bnn_pkg::*;

  // One extra bit so a slot count equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] c_lim_k1 = (ADDR_W+1)'(N_K1);
  localparam logic [ADDR_W:0] c_lim_k2 = (ADDR_W+1)'(N_K2);
  localparam logic [ADDR_W:0] c_lim_fc = (ADDR_W+1)'(N_FC);

  logic [ADDR_W:0] w_addr_x;

  assign w_addr_x = {1'b0, addr};

  always_comb begin
    valid = 1'b0;
    case (layer)
      LAYER_CONV1: valid = (w_addr_x < c_lim_k1);
      LAYER_CONV2: valid = (w_addr_x < c_lim_k2);
      LAYER_FC:    valid = (w_addr_x < c_lim_fc);
      default:     valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bnn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : bnn_weight_loader
// Description : Parses an 8-byte-per-record weight stream into single-cycle
//               kernel write commands. Bad records are dropped and flagged.
// Ports       : clk, rst_n        - clock, async active-low reset
//               load_en           - permits byte intake
//               sync_clr          - synchronous parser abort / counter clear
//               in_valid/in_ready/in_data - byte stream handshake
//               kernel_in_valid   - one-cycle write strobe
//               kernel_layer/addr/offset/bits - write command fields
//               rec_count         - emitted records, saturating
//               err               - sticky bad-record flag
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_weight_loader #(
  parameter int bW     = 8,
  parameter int ADDR_W = 11,
  parameter int N_K1   = bnn_pkg::N_K1,
  parameter int N_K2   = bnn_pkg::N_K2,
  parameter int N_FC   = bnn_pkg::N_FC,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              sync_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              kernel_in_valid,
  output logic [1:0]        kernel_layer,
  output logic [ADDR_W-1:0] kernel_addr,
  output logic [bW-1:0]     kernel_offset,
  output logic [24:0]       kernel_bits,
  output logic [CNT_W-1:0]  rec_count,
  output logic              err
);
  import bnn_pkg::*;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_ALO  = 3'd1,
    ST_AHI  = 3'd2,
    ST_OFS  = 3'd3,
    ST_PAY  = 3'd4,
    ST_EMIT = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_pay_cnt;
  logic [1:0]        r_layer;
  logic [ADDR_W-1:0] r_addr;
  logic [bW-1:0]     r_offset;
  logic [24:0]       r_pay;

  logic [1:0]        r_out_layer;
  logic [ADDR_W-1:0] r_out_addr;
  logic [bW-1:0]     r_out_offset;
  logic [24:0]       r_out_bits;
  logic [CNT_W-1:0]  r_rec_count;
  logic              r_err;

  logic w_accept;
  logic w_rec_ok;
  logic w_in_emit;
  logic w_fire;
  logic w_drop;

  // rst_n gates in_ready so the source sees no room while held in reset
  assign in_ready  = rst_n & load_en & (r_state != ST_EMIT);
  assign w_accept  = in_valid & in_ready;
  assign w_in_emit = (r_state == ST_EMIT);

  bnn_rec_check #(
    .ADDR_W (ADDR_W),
    .N_K1   (N_K1),
    .N_K2   (N_K2),
    .N_FC   (N_FC)
  ) u_rec_check (
    .layer (r_layer),
    .addr  (r_addr),
    .valid (w_rec_ok)
  );

  // sync_clr suppresses the strobe in the same cycle, hence combinational
  assign w_fire = w_in_emit & w_rec_ok & ~sync_clr;
  assign w_drop = w_in_emit & ~w_rec_ok & ~sync_clr;

  // During the strobe the fields come straight from the holding registers;
  // otherwise the last emitted command is shown.
  assign kernel_in_valid = w_fire;
  assign kernel_layer    = w_fire ? r_layer  : r_out_layer;
  assign kernel_addr     = w_fire ? r_addr   : r_out_addr;
  assign kernel_offset   = w_fire ? r_offset : r_out_offset;
  assign kernel_bits     = w_fire ? r_pay    : r_out_bits;
  assign rec_count       = r_rec_count;
  assign err             = r_err;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (sync_clr) begin
      w_state_nxt = ST_HDR;
    end else begin
      case (r_state)
        ST_HDR:  if (w_accept) w_state_nxt = ST_ALO;
        ST_ALO:  if (w_accept) w_state_nxt = ST_AHI;
        ST_AHI:  if (w_accept) w_state_nxt = ST_OFS;
        ST_OFS:  if (w_accept) w_state_nxt = ST_PAY;
        ST_PAY:  if (w_accept && (r_pay_cnt == 2'd3)) w_state_nxt = ST_EMIT;
        ST_EMIT: w_state_nxt = ST_HDR;
        default: w_state_nxt = ST_HDR;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Field holding registers, latched as each byte is accepted
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pay_cnt <= 2'd0;
      r_layer   <= 2'd0;
      r_addr    <= '0;
      r_offset  <= '0;
      r_pay     <= '0;
    end else if (sync_clr) begin
      r_pay_cnt <= 2'd0;
    end else if (w_accept) begin
      case (r_state)
        ST_HDR: r_layer     <= in_data[1:0];
        ST_ALO: r_addr[7:0] <= in_data;
        ST_AHI: r_addr[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
        ST_OFS: r_offset    <= in_data[bW-1:0];
        ST_PAY: begin
          // Counter wraps 3 -> 0 on the last payload byte
          r_pay_cnt <= r_pay_cnt + 2'd1;
          case (r_pay_cnt)
            2'd0:    r_pay[7:0]   <= in_data;
            2'd1:    r_pay[15:8]  <= in_data;
            2'd2:    r_pay[23:16] <= in_data;
            default: r_pay[24]    <= in_data[0];
          endcase
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Emitted command, record counter and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_layer  <= 2'd0;
      r_out_addr   <= '0;
      r_out_offset <= '0;
      r_out_bits   <= '0;
      r_rec_count  <= '0;
      r_err        <= 1'b0;
    end else if (sync_clr) begin
      r_rec_count  <= '0;
      r_err        <= 1'b0;
    end else if (w_fire) begin
      r_out_layer  <= r_layer;
      r_out_addr   <= r_addr;
      r_out_offset <= r_offset;
      r_out_bits   <= r_pay;
      if (r_rec_count != {CNT_W{1'b1}}) begin
        r_rec_count <= r_rec_count + CNT_W'(1);
      end
    end else if (w_drop) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_weight_loader
// Description : Self-checking bench for bnn_weight_loader. Records are built
//               byte by byte; the expected kernel command for each valid
//               record is queued and a monitor compares it when the strobe
//               appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_weight_loader;
  localparam int bW     = 8;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_en = 1'b0;
  logic              sync_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              kernel_in_valid;
  logic [1:0]        kernel_layer;
  logic [ADDR_W-1:0] kernel_addr;
  logic [bW-1:0]     kernel_offset;
  logic [24:0]       kernel_bits;
  logic [CNT_W-1:0]  rec_count;
  logic              err;

  bnn_weight_loader #(
    .bW(bW), .ADDR_W(ADDR_W), .N_K1(90), .N_K2(1080), .N_FC(10), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .kernel_in_valid(kernel_in_valid), .kernel_layer(kernel_layer),
    .kernel_addr(kernel_addr), .kernel_offset(kernel_offset),
    .kernel_bits(kernel_bits), .rec_count(rec_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [7:0]  ofs;
    logic [24:0] bits;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_count = 0;
  bit exp_err = 1'b0;

  logic [1:0]  last_layer = '0;
  logic [10:0] last_addr = '0;
  logic [7:0]  last_ofs = '0;
  logic [24:0] last_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lim(input logic [1:0] l);
    case (l)
      2'd1: return 90;
      2'd2: return 1080;
      2'd3: return 10;
      default: return 0;
    endcase
  endfunction

  // Monitor: every strobe must match the head of the scoreboard; between
  // strobes the command fields must keep the last emitted values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kernel_in_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe got layer=%0d addr=%0d ofs=%h bits=%h",
                   kernel_layer, kernel_addr, kernel_offset, kernel_bits);
        end else begin
          e = sb.pop_front();
          if (kernel_layer !== e.layer || kernel_addr !== e.addr ||
              kernel_offset !== e.ofs || kernel_bits !== e.bits || cyc != e.cyc) begin
            failures++;
            $display("FAIL strobe got layer=%0d addr=%0d ofs=%h bits=%h cyc=%0d exp layer=%0d addr=%0d ofs=%h bits=%h cyc=%0d",
                     kernel_layer, kernel_addr, kernel_offset, kernel_bits, cyc,
                     e.layer, e.addr, e.ofs, e.bits, e.cyc);
          end
          last_layer = e.layer;
          last_addr  = e.addr;
          last_ofs   = e.ofs;
          last_bits  = e.bits;
        end
      end else begin
        checks++;
        if (kernel_layer !== last_layer || kernel_addr !== last_addr ||
            kernel_offset !== last_ofs || kernel_bits !== last_bits) begin
          failures++;
          $display("FAIL hold got layer=%0d addr=%0d ofs=%h bits=%h exp layer=%0d addr=%0d ofs=%h bits=%h",
                   kernel_layer, kernel_addr, kernel_offset, kernel_bits,
                   last_layer, last_addr, last_ofs, last_bits);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Present one byte and return the cycle number just after it was accepted
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got in_ready=0 exp in_ready=1");
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  // Pause intake; with drop_le the source keeps offering a junk byte that
  // must not be taken while load_en is low.
  task automatic stall(input int n, input bit drop_le);
    @(negedge clk);
    in_valid = 1'b0;
    if (drop_le) begin
      load_en  = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hEE;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (drop_le) check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    load_en  = 1'b1;
  endtask

  task automatic send_record(input logic [7:0] r [8], input bit rnd_stall,
                             output int first_cyc, output int last_cyc);
    logic [1:0]  l;
    logic [10:0] a;
    logic [24:0] bits;
    int c;
    bit ok;
    l    = r[0][1:0];
    a    = {r[2][2:0], r[1]};
    bits = {r[7][0], r[6], r[5], r[4]};
    ok   = (l != 2'd0) && (int'(a) < lim(l));
    first_cyc = -1;
    c = -1;
    for (int i = 0; i < 8; i++) begin
      if (rnd_stall && $urandom_range(0, 4) == 0)
        stall(int'($urandom_range(1, 4)), $urandom_range(0, 1) == 1);
      send_byte(r[i], c);
      if (i == 0) first_cyc = c;
    end
    last_cyc = c;
    if (ok) begin
      sb.push_back('{l, a, r[3], bits, c});
      if (exp_count != (1 << CNT_W) - 1) exp_count++;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_count"}, int'(rec_count), exp_count);
    check({name, "_err"}, int'(err), int'(exp_err));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_ready"}, int'(in_ready), 0);
    check({name, "_strobe"}, int'(kernel_in_valid), 0);
    check({name, "_layer"}, int'(kernel_layer), 0);
    check({name, "_addr"}, int'(kernel_addr), 0);
    check({name, "_ofs"}, int'(kernel_offset), 0);
    check({name, "_bits"}, int'(kernel_bits), 0);
    check({name, "_count"}, int'(rec_count), 0);
    check({name, "_err"}, int'(err), 0);
  endtask

  logic [7:0] rec [8];
  int f0, l0, f1, l1, c;

  initial begin
    // Reset state with the source ready to go
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #2; rst_n = 1'b1;

    // Basic conv1 record at full rate
    rec = '{8'h01, 8'h05, 8'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h01};
    send_record(rec, 1'b0, f0, l0);
    check("full_rate_intake", l0 - f0, 7);
    check_status("rec_conv1");

    // conv2 last slot, then one past the end, back to back
    rec = '{8'h02, 8'h37, 8'h04, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_record(rec, 1'b0, f0, l0);
    rec = '{8'h02, 8'h38, 8'h04, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_record(rec, 1'b0, f1, l1);
    check("record_period", f1 - f0, 9);
    check_status("conv2_bounds");

    // FC last row, then a layer-0 record
    rec = '{8'h03, 8'h09, 8'h00, 8'hAA, 8'h0F, 8'h00, 8'hF0, 8'h00};
    send_record(rec, 1'b0, f0, l0);
    rec = '{8'hFC, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_record(rec, 1'b0, f0, l0);
    check_status("fc_and_layer0");

    // load_en dropped after the offset byte
    rec = '{8'h01, 8'h10, 8'h00, 8'h33, 8'hA5, 8'h5A, 8'hC3, 8'h01};
    for (int i = 0; i < 4; i++) send_byte(rec[i], c);
    stall(5, 1'b1);
    for (int i = 4; i < 8; i++) send_byte(rec[i], c);
    sb.push_back('{2'd1, 11'd16, 8'h33, 25'h1C35AA5, c});
    exp_count++;
    check_status("load_en_stall");

    // Async reset in the middle of the payload
    rec = '{8'h02, 8'h20, 8'h01, 8'h44, 8'h11, 8'h22, 8'h33, 8'h01};
    for (int i = 0; i < 6; i++) send_byte(rec[i], c);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    last_layer = '0; last_addr = '0; last_ofs = '0; last_bits = '0;
    exp_count = 0;
    exp_err = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    @(posedge clk); #2; rst_n = 1'b1;
    rec = '{8'h03, 8'h02, 8'h00, 8'h5C, 8'hFE, 8'hDC, 8'hBA, 8'h00};
    send_record(rec, 1'b0, f0, l0);
    check_status("after_reset");

    // Set err, then abort a record with sync_clr on its last byte
    rec = '{8'h01, 8'h5A, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
    send_record(rec, 1'b0, f0, l0);
    check_status("conv1_oob");
    rec = '{8'h01, 8'h07, 8'h00, 8'h99, 8'h0A, 8'h0B, 8'h0C, 8'h01};
    for (int i = 0; i < 7; i++) send_byte(rec[i], c);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rec[7];
    sync_clr = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    check("clr_strobe", int'(kernel_in_valid), 0);
    check("clr_count", int'(rec_count), 0);
    check("clr_err", int'(err), 0);
    rec = '{8'h02, 8'h00, 8'h00, 8'h77, 8'h81, 8'h42, 8'h24, 8'h01};
    send_record(rec, 1'b0, f0, l0);
    check_status("after_clr");

    // Randomised records around the address bounds, with random stalls
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  l;
      logic [10:0] a;
      int lm;
      l  = 2'($urandom_range(0, 3));
      lm = (l == 2'd0) ? 16 : lim(l);
      case ($urandom_range(0, 3))
        0: a = 11'(lm - 1);
        1: a = 11'(lm);
        2: a = 11'($urandom_range(0, lm - 1));
        default: a = 11'($urandom_range(0, 2047));
      endcase
      rec[0] = {6'($urandom), l};
      rec[1] = a[7:0];
      rec[2] = {5'($urandom), a[10:8]};
      for (int i = 3; i < 8; i++) rec[i] = 8'($urandom);
      send_record(rec, 1'b1, f0, l0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    check_status("random");

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
